// File: rtl/sig_align_pipe_if.sv
// Beat-level bus of the significand aligner: upstream valid/ready with per-lane
// operands, downstream valid/ready with the two signed adder copies and sticky bits.
interface sig_align_pipe_if #(
  parameter int unsigned expWidth   = 4,
  parameter int unsigned sigWidth   = 4,
  parameter int unsigned low_expand = 2,
  parameter int unsigned LANES      = 4
);
  localparam int unsigned SW = sigWidth + 4 + low_expand;

  logic                         in_valid;
  logic                         in_ready;
  logic [expWidth*LANES-1:0]    exp_offset_num;
  logic [sigWidth*LANES-1:0]    significand;
  logic [LANES-1:0]             sign;
  logic [LANES-1:0]             lane_en;
  logic [LANES-1:0]             complement_sign1;
  logic [LANES-1:0]             complement_sign2;
  logic                         out_valid;
  logic                         out_ready;
  logic [SW*LANES-1:0]          adder_num1;
  logic [SW*LANES-1:0]          adder_num2;
  logic [LANES-1:0]             sticky;

  modport master (
    output in_valid, exp_offset_num, significand, sign, lane_en,
           complement_sign1, complement_sign2, out_ready,
    input  in_ready, out_valid, adder_num1, adder_num2, sticky
  );

  modport slave (
    input  in_valid, exp_offset_num, significand, sign, lane_en,
           complement_sign1, complement_sign2, out_ready,
    output in_ready, out_valid, adder_num1, adder_num2, sticky
  );
endinterface

// File: rtl/sig_align_pipe.sv
// Two-stage pipelined significand aligner: S1 shifts and collects sticky, S2 builds the
// two's-complement lane words for both adder trees. Valid/ready on both sides.
module sig_align_pipe #(
  parameter int unsigned expWidth   = 4,
  parameter int unsigned sigWidth   = 4,
  parameter int unsigned low_expand = 2,
  parameter int unsigned LANES      = 4
) (
  input logic            clk,
  input logic            rst,
  input logic            flush,
  sig_align_pipe_if.slave bus
);
  localparam int unsigned SW = sigWidth + 4 + low_expand;
  localparam int unsigned MW = SW - 1;

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s1_load, s2_load;

  logic [LANES-1:0][MW-1:0] mag_d, s1_mag;
  logic [LANES-1:0]         sticky_d, zero_d;
  logic [LANES-1:0]         s1_sticky, s1_zero, s1_cs1, s1_cs2;
  logic [LANES-1:0][SW-1:0] num1_d, num2_d, s2_num1, s2_num2;
  logic [LANES-1:0]         s2_sticky;

  assign s2_adv  = !s2_valid || bus.out_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign s1_load = bus.in_valid && s1_adv && !flush;
  assign s2_load = s1_valid && s2_adv && !flush;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [MW-1:0] full;
    logic [MW-1:0] mag;
    logic [31:0]   off;

    assign full = MW'({3'b001, bus.significand[l*sigWidth +: sigWidth]}) << low_expand;
    assign off  = 32'(bus.exp_offset_num[l*expWidth +: expWidth]);
    assign mag  = (off >= MW) ? '0 : full >> off;

    // Shifts past the whole word lose every magnitude bit into sticky.
    assign sticky_d[l] = bus.lane_en[l] &
                         ((off >= MW) ? |full : |(full & ~({MW{1'b1}} << off)));
    assign zero_d[l]   = (mag == '0) || !bus.lane_en[l];
    assign mag_d[l]    = mag;

    assign num1_d[l] = s1_zero[l] ? '0 :
                       {s1_cs1[l], s1_cs1[l] ? MW'(~s1_mag[l] + 1'b1) : s1_mag[l]};
    assign num2_d[l] = s1_zero[l] ? '0 :
                       {s1_cs2[l], s1_cs2[l] ? MW'(~s1_mag[l] + 1'b1) : s1_mag[l]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_mag    <= '0;
      s1_sticky <= '0;
      s1_zero   <= '0;
      s1_cs1    <= '0;
      s1_cs2    <= '0;
      s2_num1   <= '0;
      s2_num2   <= '0;
      s2_sticky <= '0;
    end else begin
      // Flush only drops valids; data registers keep their contents.
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s1_adv) s1_valid <= bus.in_valid;
        if (s2_adv) s2_valid <= s1_valid;
      end
      if (s1_load) begin
        s1_mag    <= mag_d;
        s1_sticky <= sticky_d;
        s1_zero   <= zero_d;
        s1_cs1    <= bus.sign ^ bus.complement_sign1;
        s1_cs2    <= bus.sign ^ bus.complement_sign2;
      end
      if (s2_load) begin
        s2_num1   <= num1_d;
        s2_num2   <= num2_d;
        s2_sticky <= s1_sticky;
      end
    end
  end

  assign bus.in_ready   = s1_adv;
  assign bus.out_valid  = s2_valid;
  assign bus.adder_num1 = s2_num1;
  assign bus.adder_num2 = s2_num2;
  assign bus.sticky     = s2_sticky;
endmodule
